// File: rtl/life_engine.sv
// Game of Life engine: double-buffered ROWSxCOLS grid, one cell of the next generation evaluated per clock.
// Latency: start sampled at edge 0 -> new generation visible after edge COLS*ROWS+1; rd_data is combinational.
// Backpressure: none; start and wr_en are ignored while busy (no queueing).
module life_engine #(
    parameter int         COLS         = 20,
    parameter int         ROWS         = 15,
    parameter logic [8:0] BIRTH_MASK   = 9'b000001000,
    parameter logic [8:0] SURVIVE_MASK = 9'b000001100,
    parameter bit         WRAP         = 1'b1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        wr_en,
    input  logic [5:0]  wr_x,
    input  logic [5:0]  wr_y,
    input  logic        wr_data,
    input  logic [5:0]  rd_x,
    input  logic [5:0]  rd_y,
    output logic        rd_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] gen_count
);
    localparam int         NCELL = COLS * ROWS;
    localparam int         IW    = $clog2(NCELL);
    localparam logic [5:0] XMAX  = 6'(COLS - 1);
    localparam logic [5:0] YMAX  = 6'(ROWS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_SWAP = 2'd2;

    logic [1:0]       state;
    logic             sel;
    logic [NCELL-1:0] buf_a;
    logic [NCELL-1:0] buf_b;
    logic [NCELL-1:0] cur;
    logic [5:0]       x;
    logic [5:0]       y;

    // Row-major flat index; only ever called with in-grid coordinates.
    function automatic logic [IW-1:0] idx(input logic [5:0] cx, input logic [5:0] cy);
        idx = IW'(cy) * IW'(COLS) + IW'(cx);
    endfunction

    assign cur = sel ? buf_b : buf_a;

    logic [5:0] xm, xp, ym, yp;
    logic       xm_ok, xp_ok, ym_ok, yp_ok;

    assign xm    = (x == 6'd0) ? XMAX : x - 6'd1;
    assign xp    = (x == XMAX) ? 6'd0 : x + 6'd1;
    assign ym    = (y == 6'd0) ? YMAX : y - 6'd1;
    assign yp    = (y == YMAX) ? 6'd0 : y + 6'd1;
    assign xm_ok = WRAP || (x != 6'd0);
    assign xp_ok = WRAP || (x != XMAX);
    assign ym_ok = WRAP || (y != 6'd0);
    assign yp_ok = WRAP || (y != YMAX);

    logic [3:0] ncount;
    logic       next_val;

    // Off-grid neighbours are masked rather than clamped, so WRAP=0 counts them as dead.
    always_comb begin
        ncount = 4'd0;
        ncount = ncount + {3'd0, xm_ok & ym_ok & cur[idx(xm, ym)]};
        ncount = ncount + {3'd0,         ym_ok & cur[idx(x,  ym)]};
        ncount = ncount + {3'd0, xp_ok & ym_ok & cur[idx(xp, ym)]};
        ncount = ncount + {3'd0, xm_ok         & cur[idx(xm, y )]};
        ncount = ncount + {3'd0, xp_ok         & cur[idx(xp, y )]};
        ncount = ncount + {3'd0, xm_ok & yp_ok & cur[idx(xm, yp)]};
        ncount = ncount + {3'd0,         yp_ok & cur[idx(x,  yp)]};
        ncount = ncount + {3'd0, xp_ok & yp_ok & cur[idx(xp, yp)]};
        next_val = cur[idx(x, y)] ? SURVIVE_MASK[ncount] : BIRTH_MASK[ncount];
    end

    logic wr_ok;
    assign wr_ok = wr_en && (state == S_IDLE) && (wr_x <= XMAX) && (wr_y <= YMAX);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= S_IDLE;
            sel       <= 1'b0;
            buf_a     <= '0;
            buf_b     <= '0;
            x         <= 6'd0;
            y         <= 6'd0;
            done      <= 1'b0;
            gen_count <= 16'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wr_ok) begin
                        if (sel) buf_b[idx(wr_x, wr_y)] <= wr_data;
                        else     buf_a[idx(wr_x, wr_y)] <= wr_data;
                    end
                    if (start) begin
                        state <= S_RUN;
                        x     <= 6'd0;
                        y     <= 6'd0;
                    end
                end
                S_RUN: begin
                    if (sel) buf_a[idx(x, y)] <= next_val;
                    else     buf_b[idx(x, y)] <= next_val;
                    if (x == XMAX) begin
                        x <= 6'd0;
                        if (y == YMAX) begin
                            y     <= 6'd0;
                            state <= S_SWAP;
                        end else begin
                            y <= y + 6'd1;
                        end
                    end else begin
                        x <= x + 6'd1;
                    end
                end
                S_SWAP: begin
                    sel       <= ~sel;
                    gen_count <= gen_count + 16'd1;
                    done      <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy    = (state == S_RUN) || (state == S_SWAP);
    assign rd_data = ((rd_x <= XMAX) && (rd_y <= YMAX)) ? cur[idx(rd_x, rd_y)] : 1'b0;

endmodule

// File: tb/tb_life_engine.sv
// Bench for life_engine: three instances (8x8 torus, 5x5 flat, 6x5 torus B36) checked against
// a cell-array reference model that applies the birth/survival rules with modulo arithmetic.
module tb_life_engine;
    localparam int ND = 3;

    logic       clk = 1'b0;
    logic       clr;
    logic       start_s   [ND];
    logic       wr_en_s   [ND];
    logic [5:0] wr_x_s    [ND];
    logic [5:0] wr_y_s    [ND];
    logic       wr_data_s [ND];
    logic [5:0] rd_x_s    [ND];
    logic [5:0] rd_y_s    [ND];

    logic        rd_data0, rd_data1, rd_data2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [15:0] gen0, gen1, gen2;

    int checks = 0;
    int errors = 0;

    int         cols  [ND] = '{8, 5, 6};
    int         rows  [ND] = '{8, 5, 5};
    bit         wrap  [ND] = '{1'b1, 1'b0, 1'b1};
    logic [8:0] birth [ND] = '{9'b000001000, 9'b000001000, 9'b001001000};
    logic [8:0] surv  [ND] = '{9'b000001100, 9'b000001100, 9'b000001100};

    bit         mg   [ND][64][64];
    logic [15:0] mgen [ND];

    always #5 clk = ~clk;

    life_engine #(.COLS(8), .ROWS(8), .WRAP(1'b1)) u_torus (
        .clk(clk), .clr(clr), .start(start_s[0]), .wr_en(wr_en_s[0]),
        .wr_x(wr_x_s[0]), .wr_y(wr_y_s[0]), .wr_data(wr_data_s[0]),
        .rd_x(rd_x_s[0]), .rd_y(rd_y_s[0]), .rd_data(rd_data0),
        .busy(busy0), .done(done0), .gen_count(gen0)
    );
    life_engine #(.COLS(5), .ROWS(5), .WRAP(1'b0)) u_flat (
        .clk(clk), .clr(clr), .start(start_s[1]), .wr_en(wr_en_s[1]),
        .wr_x(wr_x_s[1]), .wr_y(wr_y_s[1]), .wr_data(wr_data_s[1]),
        .rd_x(rd_x_s[1]), .rd_y(rd_y_s[1]), .rd_data(rd_data1),
        .busy(busy1), .done(done1), .gen_count(gen1)
    );
    life_engine #(.COLS(6), .ROWS(5), .WRAP(1'b1), .BIRTH_MASK(9'b001001000)) u_b36 (
        .clk(clk), .clr(clr), .start(start_s[2]), .wr_en(wr_en_s[2]),
        .wr_x(wr_x_s[2]), .wr_y(wr_y_s[2]), .wr_data(wr_data_s[2]),
        .rd_x(rd_x_s[2]), .rd_y(rd_y_s[2]), .rd_data(rd_data2),
        .busy(busy2), .done(done2), .gen_count(gen2)
    );

    function automatic logic get_busy(input int d);
        case (d) 0: return busy0; 1: return busy1; default: return busy2; endcase
    endfunction
    function automatic logic get_done(input int d);
        case (d) 0: return done0; 1: return done1; default: return done2; endcase
    endfunction
    function automatic logic [15:0] get_gen(input int d);
        case (d) 0: return gen0; 1: return gen1; default: return gen2; endcase
    endfunction

    task automatic read_cell(input int d, input int cx, input int cy, output logic v);
        rd_x_s[d] = 6'(cx);
        rd_y_s[d] = 6'(cy);
        #1;
        case (d) 0: v = rd_data0; 1: v = rd_data1; default: v = rd_data2; endcase
    endtask

    // Counts displayed cells (including a margin of off-grid coordinates) that disagree with the model.
    task automatic grid_diff(input int d, output int bad);
        logic v;
        bit   e;
        bad = 0;
        for (int yy = 0; yy < rows[d] + 2; yy++) begin
            for (int xx = 0; xx < cols[d] + 2; xx++) begin
                read_cell(d, xx, yy, v);
                e = (xx < cols[d] && yy < rows[d]) ? mg[d][xx][yy] : 1'b0;
                if (v !== e) bad++;
            end
        end
        read_cell(d, 63, 63, v);
        if (v !== 1'b0) bad++;
    endtask

    task automatic model_step(input int d);
        bit t [64][64];
        int n, xx, yy;
        for (int cy = 0; cy < rows[d]; cy++) begin
            for (int cx = 0; cx < cols[d]; cx++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        if (dx == 0 && dy == 0) continue;
                        xx = cx + dx;
                        yy = cy + dy;
                        if (wrap[d]) begin
                            xx = (xx + cols[d]) % cols[d];
                            yy = (yy + rows[d]) % rows[d];
                        end else if (xx < 0 || xx >= cols[d] || yy < 0 || yy >= rows[d]) begin
                            continue;
                        end
                        n += int'(mg[d][xx][yy]);
                    end
                end
                t[cx][cy] = mg[d][cx][cy] ? surv[d][n] : birth[d][n];
            end
        end
        for (int cy = 0; cy < rows[d]; cy++)
            for (int cx = 0; cx < cols[d]; cx++)
                mg[d][cx][cy] = t[cx][cy];
        mgen[d] = mgen[d] + 16'd1;
    endtask

    task automatic write_cell(input int d, input int cx, input int cy, input bit v);
        @(negedge clk);
        wr_en_s[d]   = 1'b1;
        wr_x_s[d]    = 6'(cx);
        wr_y_s[d]    = 6'(cy);
        wr_data_s[d] = v;
        @(negedge clk);
        wr_en_s[d] = 1'b0;
        if (cx < cols[d] && cy < rows[d]) mg[d][cx][cy] = v;
    endtask

    task automatic clear_grid(input int d);
        for (int cy = 0; cy < rows[d]; cy++)
            for (int cx = 0; cx < cols[d]; cx++)
                if (mg[d][cx][cy]) write_cell(d, cx, cy, 1'b0);
    endtask

    // Pulses start (optionally with a same-cycle write); edges = edge index at which done appeared.
    task automatic run_gen(input int d, input bit do_wr, input int wx, input int wy, input bit wv,
                           output int edges, output int anom);
        int n;
        n = cols[d] * rows[d];
        edges = -1;
        anom = 0;
        @(negedge clk);
        start_s[d] = 1'b1;
        if (do_wr) begin
            wr_en_s[d] = 1'b1; wr_x_s[d] = 6'(wx); wr_y_s[d] = 6'(wy); wr_data_s[d] = wv;
        end
        @(negedge clk);
        start_s[d] = 1'b0;
        wr_en_s[d] = 1'b0;
        if (do_wr && wx < cols[d] && wy < rows[d]) mg[d][wx][wy] = wv;
        if (get_busy(d) !== 1'b1) anom++;
        for (int k = 1; k <= n + 20; k++) begin
            @(negedge clk);
            if (get_done(d) === 1'b1) begin
                edges = k;
                if (get_busy(d) !== 1'b0) anom++;
                break;
            end
            if (get_busy(d) !== 1'b1) anom++;
        end
        @(negedge clk);
        if (get_done(d) !== 1'b0) anom++;
        model_step(d);
    endtask

    task automatic test_reset();
        int bad;
        clr = 1'b0;
        for (int d = 0; d < ND; d++) begin
            start_s[d] = 0; wr_en_s[d] = 0; wr_x_s[d] = 0; wr_y_s[d] = 0;
            wr_data_s[d] = 0; rd_x_s[d] = 0; rd_y_s[d] = 0; mgen[d] = 16'd0;
            for (int i = 0; i < 64; i++) for (int j = 0; j < 64; j++) mg[d][i][j] = 1'b0;
        end
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            checks++; if (get_busy(d) !== 1'b0) begin errors++; $display("FAIL reset_busy inst %0d got %b want 0", d, get_busy(d)); end
            checks++; if (get_done(d) !== 1'b0) begin errors++; $display("FAIL reset_done inst %0d got %b want 0", d, get_done(d)); end
            checks++; if (get_gen(d) !== 16'd0) begin errors++; $display("FAIL reset_gen inst %0d got %0d want 0", d, get_gen(d)); end
            grid_diff(d, bad);
            checks++; if (bad !== 0) begin errors++; $display("FAIL reset_grid inst %0d got %0d bad cells want 0", d, bad); end
        end
    endtask

    task automatic test_blinker();
        int edges, anom, bad;
        logic v;
        write_cell(1, 1, 2, 1'b1);
        write_cell(1, 2, 2, 1'b1);
        write_cell(1, 3, 2, 1'b1);
        run_gen(1, 1'b0, 0, 0, 1'b0, edges, anom);
        checks++; if (edges !== 26) begin errors++; $display("FAIL blinker_latency got %0d want 26", edges); end
        checks++; if (anom !== 0) begin errors++; $display("FAIL blinker_busy_done got %0d anomalies want 0", anom); end
        read_cell(1, 2, 1, v);
        checks++; if (v !== 1'b1) begin errors++; $display("FAIL blinker_vertical got %b want 1", v); end
        read_cell(1, 1, 2, v);
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL blinker_end_died got %b want 0", v); end
        grid_diff(1, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL blinker_gen1 got %0d bad cells want 0", bad); end
        run_gen(1, 1'b0, 0, 0, 1'b0, edges, anom);
        read_cell(1, 3, 2, v);
        checks++; if (v !== 1'b1) begin errors++; $display("FAIL blinker_restore got %b want 1", v); end
        grid_diff(1, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL blinker_gen2 got %0d bad cells want 0", bad); end
        checks++; if (gen1 !== 16'd2) begin errors++; $display("FAIL blinker_gen_count got %0d want 2", gen1); end
    endtask

    task automatic test_back_to_back();
        int gx [5] = '{1, 2, 0, 1, 2};
        int gy [5] = '{0, 1, 2, 2, 2};
        bit seed [8][8];
        int cyc, ndone, first, last, spacing_bad, bad;
        logic v;
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) seed[i][j] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            write_cell(0, gx[i], gy[i], 1'b1);
            seed[gx[i]][gy[i]] = 1'b1;
        end
        @(negedge clk);
        start_s[0] = 1'b1;
        cyc = 0; ndone = 0; first = -1; last = -1; spacing_bad = 0;
        while (ndone < 32 && cyc < 32 * 66 + 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done0 === 1'b1) begin
                if (ndone == 0) first = cyc;
                else if (cyc - last != 66) spacing_bad++;
                last = cyc;
                ndone++;
                if (ndone == 32) start_s[0] = 1'b0;
                model_step(0);
            end
        end
        start_s[0] = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ndone !== 32) begin errors++; $display("FAIL glider_done_count got %0d want 32", ndone); end
        checks++; if (first !== 66) begin errors++; $display("FAIL glider_first_done got cycle %0d want 66", first); end
        checks++; if (spacing_bad !== 0) begin errors++; $display("FAIL glider_spacing got %0d bad gaps want 0", spacing_bad); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL glider_idle_after got %b want 0", busy0); end
        checks++; if (gen0 !== 16'd32) begin errors++; $display("FAIL glider_gen_count got %0d want 32", gen0); end
        bad = 0;
        for (int cy = 0; cy < 8; cy++)
            for (int cx = 0; cx < 8; cx++) begin
                read_cell(0, cx, cy, v);
                if (v !== seed[cx][cy]) bad++;
            end
        checks++; if (bad !== 0) begin errors++; $display("FAIL glider_returns got %0d bad cells want 0", bad); end
        grid_diff(0, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL glider_model got %0d bad cells want 0", bad); end
    endtask

    task automatic test_topology();
        int edges, anom, bad, ones;
        logic v;
        clear_grid(0);
        write_cell(0, 0, 0, 1'b1);
        write_cell(0, 0, 7, 1'b1);
        write_cell(0, 7, 0, 1'b1);
        run_gen(0, 1'b0, 0, 0, 1'b0, edges, anom);
        read_cell(0, 7, 7, v);
        checks++; if (v !== 1'b1) begin errors++; $display("FAIL torus_corner_birth got %b want 1", v); end
        grid_diff(0, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL torus_grid got %0d bad cells want 0", bad); end
        clear_grid(1);
        write_cell(1, 0, 0, 1'b1);
        write_cell(1, 0, 4, 1'b1);
        write_cell(1, 4, 0, 1'b1);
        run_gen(1, 1'b0, 0, 0, 1'b0, edges, anom);
        ones = 0;
        for (int cy = 0; cy < 5; cy++)
            for (int cx = 0; cx < 5; cx++) begin
                read_cell(1, cx, cy, v);
                if (v !== 1'b0) ones++;
            end
        checks++; if (ones !== 0) begin errors++; $display("FAIL flat_corners_die got %0d live cells want 0", ones); end
    endtask

    task automatic test_custom_rule();
        int edges, anom, bad;
        logic v;
        clear_grid(0);
        for (int cx = 1; cx <= 3; cx++) begin
            write_cell(2, cx, 1, 1'b1); write_cell(2, cx, 3, 1'b1);
            write_cell(0, cx, 1, 1'b1); write_cell(0, cx, 3, 1'b1);
        end
        run_gen(2, 1'b0, 0, 0, 1'b0, edges, anom);
        run_gen(0, 1'b0, 0, 0, 1'b0, edges, anom);
        read_cell(2, 2, 2, v);
        checks++; if (v !== 1'b1) begin errors++; $display("FAIL b36_birth6 got %b want 1", v); end
        read_cell(0, 2, 2, v);
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL b3_no_birth6 got %b want 0", v); end
        grid_diff(2, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL b36_grid got %0d bad cells want 0", bad); end
    endtask

    task automatic test_lockout();
        int n, cyc, extra, bad;
        logic v;
        logic [15:0] g_before;
        n = 64;
        write_cell(0, 0, 0, 1'b0);
        g_before = gen0;
        @(negedge clk); start_s[0] = 1'b1;
        @(negedge clk); start_s[0] = 1'b0;
        repeat (5) @(negedge clk);
        wr_en_s[0] = 1'b1; wr_x_s[0] = 6'd0; wr_y_s[0] = 6'd0; wr_data_s[0] = 1'b1; start_s[0] = 1'b1;
        @(negedge clk);
        wr_en_s[0] = 1'b0; start_s[0] = 1'b0;
        read_cell(0, 0, 0, v);
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL lockout_write got %b want 0", v); end
        cyc = 0;
        while (done0 !== 1'b1 && cyc < n + 20) begin @(negedge clk); cyc++; end
        checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL lockout_timeout got done %b want 1", done0); end
        model_step(0);
        extra = 0;
        for (int k = 0; k < n + 10; k++) begin
            @(negedge clk);
            if (done0 === 1'b1 || busy0 === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL lockout_extra_gen got %0d busy cycles want 0", extra); end
        checks++; if (gen0 !== g_before + 16'd1) begin errors++; $display("FAIL lockout_gen_count got %0d want %0d", gen0, g_before + 16'd1); end
        grid_diff(0, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL lockout_grid got %0d bad cells want 0", bad); end
    endtask

    task automatic test_random();
        int edges, anom, bad;
        for (int d = 0; d < ND; d++) begin
            for (int r = 0; r < 3; r++) begin
                for (int cy = 0; cy < rows[d]; cy++)
                    for (int cx = 0; cx < cols[d]; cx++)
                        write_cell(d, cx, cy, ($urandom_range(0, 2) == 0));
                for (int i = 0; i < 3; i++)
                    write_cell(d, cols[d] + int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), 1'b1);
                run_gen(d, 1'b1, int'($urandom_range(0, cols[d] - 1)), int'($urandom_range(0, rows[d] - 1)),
                        1'($urandom_range(0, 1)), edges, anom);
                checks++; if (edges !== cols[d] * rows[d] + 1) begin errors++; $display("FAIL rand_latency inst %0d got %0d want %0d", d, edges, cols[d] * rows[d] + 1); end
                checks++; if (anom !== 0) begin errors++; $display("FAIL rand_busy_done inst %0d got %0d anomalies want 0", d, anom); end
                grid_diff(d, bad);
                checks++; if (bad !== 0) begin errors++; $display("FAIL rand_grid inst %0d round %0d got %0d bad cells want 0", d, r, bad); end
                run_gen(d, 1'b0, 0, 0, 1'b0, edges, anom);
                grid_diff(d, bad);
                checks++; if (bad !== 0) begin errors++; $display("FAIL rand_grid2 inst %0d round %0d got %0d bad cells want 0", d, r, bad); end
                checks++; if (get_gen(d) !== mgen[d]) begin errors++; $display("FAIL rand_gen_count inst %0d got %0d want %0d", d, get_gen(d), mgen[d]); end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int edges, anom, bad;
        for (int cy = 0; cy < 8; cy++)
            for (int cx = 0; cx < 8; cx++)
                write_cell(0, cx, cy, ($urandom_range(0, 1) == 1));
        @(negedge clk); start_s[0] = 1'b1;
        @(negedge clk); start_s[0] = 1'b0;
        repeat (9) @(negedge clk);
        clr = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            mgen[d] = 16'd0;
            for (int i = 0; i < 64; i++) for (int j = 0; j < 64; j++) mg[d][i][j] = 1'b0;
        end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy0); end
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", done0); end
        checks++; if (gen0 !== 16'd0) begin errors++; $display("FAIL midrst_gen got %0d want 0", gen0); end
        grid_diff(0, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL midrst_grid got %0d bad cells want 0", bad); end
        @(negedge clk);
        clr = 1'b1;
        write_cell(0, 3, 3, 1'b1);
        write_cell(0, 4, 3, 1'b1);
        run_gen(0, 1'b1, 5, 3, 1'b1, edges, anom);
        checks++; if (edges !== 65) begin errors++; $display("FAIL midrst_rerun_latency got %0d want 65", edges); end
        checks++; if (gen0 !== 16'd1) begin errors++; $display("FAIL midrst_rerun_gen got %0d want 1", gen0); end
        grid_diff(0, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL midrst_rerun_grid got %0d bad cells want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_blinker();
        test_back_to_back();
        test_topology();
        test_custom_rule();
        test_lockout();
        test_random();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
